ifetch_buf: RTL and testbench

Parametrised instruction-fetch stage with a decoupling fetch queue between instruction memory and decode. Generates the PC, reads one instruction per cycle from a combinational instruction memory, applies static branch/jump prediction, and pushes {pc, instr, take} into a QDEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake. JALR waits for the decode-stage target; a branch mispredict flushes the FIFO and redirects.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/ifetch_buf.sv | 112 +++++++++++
 tb/tb_ifetch_buf.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, FSM states and
// RV32 immediate extraction.
package fetch_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef enum logic [0:0] {
    FETCH     = 1'b0,
    WAIT_JALR = 1'b1
  } fetch_state_e;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  // Both return the immediate already sign-extended to 32 bits.
  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two depth FIFO with synchronous reset (clears storage) and a flush
// that only rewinds the pointers and count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_buf.sv
// Fetch stage: PC generation, static branch/jump prediction and fetch queue.
// Optional IFETCH_BTFN_EN: predict backward branches taken.
//
// state     | meaning
// FETCH     | reading imem and enqueueing one instruction per cycle
// WAIT_JALR | JALR queued, fetch stalled until decode supplies its target
module ifetch_buf
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              QDEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               pc_rst,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_take,
  input  logic               id_jalr,
  input  logic [PC_W-1:0]    id_reg_value,
  input  logic               predict_fail,
  input  logic [PC_W-1:0]    fail_pc
);

  localparam int ENT_W = PC_W + INSTR_W + 1;
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              fetch_en;
  logic              take;
  logic [31:0]       instr32;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_head;

  assign instr32 = imem_rdata[31:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fetch_en = 1'b0;
    take     = 1'b0;
    if (predict_fail) begin
      pc_d    = fail_pc;
      state_d = FETCH;
    end else if (state_q == WAIT_JALR) begin
      if (id_jalr) begin
        pc_d    = id_reg_value & ~PC_W'(1);
        state_d = FETCH;
      end
    end else if (!fifo_full) begin
      fetch_en = 1'b1;
      pc_d     = pc_q + PC_W'(4);
      case (get_opcode(instr32))
        OP_JAL: begin
          take = 1'b1;
          pc_d = pc_q + PC_W'(signed'(imm_j(instr32)));
        end
        OP_BRANCH: begin
`ifdef IFETCH_BTFN_EN
          take = instr32[31];
`endif
          if (take) pc_d = pc_q + PC_W'(signed'(imm_b(instr32)));
        end
        OP_JALR: begin
          pc_d    = pc_q;
          state_d = WAIT_JALR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pc_rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_en   = fetch_en & ~pc_rst;
  assign imem_addr = pc_rst ? RESET_PC : pc_q;
  assign out_valid = (fifo_count != '0) & ~predict_fail & ~pc_rst;

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (pc_rst),
    .flush (predict_fail),
    .push  (imem_en),
    .wdata ({pc_q, imem_rdata, take}),
    .pop   (out_valid & out_ready),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign {out_pc, out_instr, out_take} = fifo_head;

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: directed scenarios plus randomized programs and
// control pulses, compared against a queue-based reference model.
module tb_ifetch_buf;
  import fetch_pkg::*;

  localparam int          PC_W     = 32;
  localparam int          INSTR_W  = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] JALR_I   = {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};

  logic               clk = 1'b0;
  logic               pc_rst = 1'b1;
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_take;
  logic               id_jalr = 1'b0;
  logic [PC_W-1:0]    id_reg_value = '0;
  logic               predict_fail = 1'b0;
  logic [PC_W-1:0]    fail_pc = '0;

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign imem_rdata = mem[imem_addr[11:2]];

  ifetch_buf #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .pc_rst(pc_rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_take(out_take),
    .id_jalr(id_jalr), .id_reg_value(id_reg_value),
    .predict_fail(predict_fail), .fail_pc(fail_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        take;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_wait = 0;
  bit          m_in_rst = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int imm);
    logic [20:0] i;
    i = imm[20:0];
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, OP_JAL};
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [12:0] i;
    i = imm[12:0];
    return {i[12], i[10:5], 5'd1, 5'd1, 3'b000, i[4:1], i[11], OP_BRANCH};
  endfunction

  // Next fetch PC from the ISA's immediate encodings and the prediction rule.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           output bit take, output bit wj);
    logic signed [20:0] jo;
    logic signed [12:0] bo;
    take = 0;
    wj   = 0;
    case (ins[6:0])
      OP_JAL: begin
        jo   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        take = 1;
        return pc + 32'(jo);
      end
      OP_BRANCH: begin
        bo = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
`ifdef IFETCH_BTFN_EN
        take = (bo < 0);
`endif
        return take ? pc + 32'(bo) : pc + 32'd4;
      end
      OP_JALR: begin
        wj = 1;
        return pc;
      end
      default: return pc + 32'd4;
    endcase
  endfunction

  // One clock: drive inputs after the falling edge, compare, advance the model.
  task automatic step(input bit rst, input bit rdy, input bit jalr, input logic [31:0] regv,
                      input bit pf, input logic [31:0] fpc);
    bit          e_en, e_val, tk, wj;
    logic [31:0] ins, nxt;
    @(negedge clk);
    pc_rst = rst; out_ready = rdy; id_jalr = jalr; id_reg_value = regv;
    predict_fail = pf; fail_pc = fpc;
    #1;
    if (rst) begin
      chk("rst_imem_en", imem_en, 0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_out_valid", out_valid, 0);
      if (m_in_rst) begin
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_take", out_take, 0);
      end
      q.delete();
      m_pc = RESET_PC; m_wait = 0; m_in_rst = 1;
      return;
    end
    m_in_rst = 0;
    e_en  = !m_wait && q.size() < QDEPTH && !pf;
    e_val = q.size() != 0 && !pf;
    chk("imem_en", imem_en, e_en);
    chk("imem_addr", imem_addr, m_pc);
    chk("out_valid", out_valid, e_val);
    if (e_val) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
      chk("out_take", out_take, q[0].take);
    end
    if (pf) begin
      q.delete();
      m_pc = fpc; m_wait = 0;
      return;
    end
    if (e_val && rdy) void'(q.pop_front());
    if (m_wait) begin
      if (jalr) begin
        m_pc = regv & ~32'd1;
        m_wait = 0;
      end
    end else if (e_en) begin
      ins = mem[m_pc[11:2]];
      nxt = ref_next(m_pc, ins, tk, wj);
      q.push_back('{pc: m_pc, instr: ins, take: tk});
      m_pc = nxt;
      m_wait = wj;
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, rdy, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 1024; i++) mem[i] = INSTR_NOP;
  endtask

  initial begin
    // Straight-line stream, first delivery one cycle after first fetch
    fill_nop();
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("first_out_pc", out_pc, 32'h0);
    run(8, 1);

    // Backpressure fills exactly QDEPTH entries then stalls at 0x10
    do_reset();
    run(10, 0);
    chk("full_addr", imem_addr, 32'h10);
    chk("full_en", imem_en, 0);
    run(8, 1);

    // JAL +0x40 at 0x8
    fill_nop();
    mem[2] = enc_jal(64);
    do_reset();
    run(3, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("jal_target", imem_addr, 32'h48);
    run(4, 1);

    // JALR at 0x4 waits for decode target, bit 0 cleared
    fill_nop();
    mem[1] = JALR_I;
    do_reset();
    run(5, 1);
    chk("jalr_wait_en", imem_en, 0);
    step(0, 1, 1, 32'h101, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("jalr_target", imem_addr, 32'h100);
    chk("jalr_resume_en", imem_en, 1);
    run(4, 1);

    // Backward BEQ at 0x20
    fill_nop();
    mem[8] = enc_b(-8);
    do_reset();
    run(9, 1);
    step(0, 1, 0, 0, 0, 0);
`ifdef IFETCH_BTFN_EN
    chk("beq_next", imem_addr, 32'h18);
`else
    chk("beq_next", imem_addr, 32'h24);
`endif
    run(4, 1);

    // Mispredict with 3 queued entries and a simultaneous id_jalr
    fill_nop();
    do_reset();
    run(3, 0);
    step(0, 1, 1, 32'h44, 1, 32'h200);
    chk("pf_valid", out_valid, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pf_addr", imem_addr, 32'h200);
    chk("pf_empty", out_valid, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("pf_head", out_pc, 32'h200);
    run(3, 1);

    // Randomized programs and control traffic
    for (int i = 0; i < 1024; i++) begin
      int r, v;
      r = int'($urandom_range(0, 99));
      if (r < 70) mem[i] = {25'($urandom), 7'b0010011};
      else if (r < 80) begin
        v = int'($urandom_range(0, 64));
        mem[i] = enc_jal((v - 32) * 4);
      end else if (r < 93) begin
        v = int'($urandom_range(0, 32));
        mem[i] = enc_b((v - 16) * 4);
      end else mem[i] = JALR_I;
    end
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit rst, rdy, jl, pf;
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      pf  = ($urandom_range(0, 39) == 0);
      jl  = m_wait && ($urandom_range(0, 3) == 0);
      step(rst, rdy, jl, $urandom, pf, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
